// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode/state types and width default for the ALU arbiter
package alu_pkg;

  localparam int WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    ALU_NOP = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_MUL = 3'd3,
    ALU_DIV = 3'd4,
    ALU_AND = 3'd5,
    ALU_OR  = 3'd6,
    ALU_NOT = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way round-robin grant selection (combinational)
module rr_arbiter_2 (
  input  logic [1:0] request,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // Under contention the requester not granted last time wins; otherwise pass the lone request.
  always_comb begin
    grant = 2'b00;
    if (request == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = request;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester front end for a shared combinational ALU (option: ALU_ARB_DIV_ZERO_CHECK_EN)
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req0_op,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req0_operand_1,
  input  logic [WIDTH-1:0] req0_operand_2,
  input  logic [WIDTH-1:0] req1_operand_1,
  input  logic [WIDTH-1:0] req1_operand_2,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_operand_1,
  output logic [WIDTH-1:0] alu_operand_2,
  input  logic [WIDTH-1:0] alu_result
);

  state_e           state, state_nxt;
  logic [1:0]       grant;
  logic [1:0]       accept;
  // Index of the most recent grant; doubles as the owner of the in-flight transaction.
  // Resets to 1 so requester 0 wins the first contention.
  logic             last_grant_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic             div_zero;

  rr_arbiter_2 u_rr (
    .request    (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Accept only in IDLE, and never while reset is asserted.
  assign accept    = (state == IDLE && rst_n) ? grant : 2'b00;
  assign req_ready = accept;

`ifdef ALU_ARB_DIV_ZERO_CHECK_EN
  logic err_q;
  assign div_zero = (op_q == ALU_DIV) && (opb_q == '0);
  assign rsp_err  = err_q;

  // Error flag is captured alongside the result at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state == EXEC) begin
      err_q <= div_zero;
    end
  end
`else
  assign div_zero = 1'b0;
  assign rsp_err  = 1'b0;
`endif

  // Next-state logic: one EXEC cycle, then hold RESP until the owner accepts.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_valid) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready[last_grant_q]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU bus is live only in EXEC; a trapped divide-by-zero keeps it at NOP.
  always_comb begin
    alu_op        = ALU_NOP;
    alu_operand_1 = '0;
    alu_operand_2 = '0;
    rsp_valid     = 2'b00;
    if (state == EXEC && !div_zero) begin
      alu_op        = op_q;
      alu_operand_1 = opa_q;
      alu_operand_2 = opb_q;
    end
    if (state == RESP) begin
      rsp_valid = last_grant_q ? 2'b10 : 2'b01;
    end
  end

  // State, request latch and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= ALU_NOP;
      opa_q        <= '0;
      opb_q        <= '0;
      rsp_result   <= '0;
    end else begin
      state <= state_nxt;
      if (|accept) begin
        last_grant_q <= accept[1];
        op_q         <= accept[1] ? req1_op        : req0_op;
        opa_q        <= accept[1] ? req1_operand_1 : req0_operand_1;
        opb_q        <= accept[1] ? req1_operand_2 : req0_operand_2;
      end
      if (state == EXEC) begin
        rsp_result <= div_zero ? '1 : alu_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [2:0]  req0_op = 3'd0;
  logic [2:0]  req1_op = 3'd0;
  logic [15:0] req0_operand_1 = 16'h0, req0_operand_2 = 16'h0;
  logic [15:0] req1_operand_1 = 16'h0, req1_operand_2 = 16'h0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b00;
  logic [15:0] rsp_result;
  logic        rsp_err;
  logic [2:0]  alu_op;
  logic [15:0] alu_operand_1, alu_operand_2;
  logic [15:0] alu_result;

  int vectors = 0;
  int miscompares = 0;

  alu_arbiter #(.WIDTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req0_op        (req0_op),
    .req1_op        (req1_op),
    .req0_operand_1 (req0_operand_1),
    .req0_operand_2 (req0_operand_2),
    .req1_operand_1 (req1_operand_1),
    .req1_operand_2 (req1_operand_2),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_result     (rsp_result),
    .rsp_err        (rsp_err),
    .alu_op         (alu_op),
    .alu_operand_1  (alu_operand_1),
    .alu_operand_2  (alu_operand_2),
    .alu_result     (alu_result)
  );

  always #5 clk = ~clk;

  // External combinational ALU the arbiter drives.
  always_comb begin
    alu_result = 16'h0;
    case (alu_op)
      3'd1: alu_result = alu_operand_1 + alu_operand_2;
      3'd2: alu_result = alu_operand_1 - alu_operand_2;
      3'd3: alu_result = 16'(alu_operand_1 * alu_operand_2);
      3'd4: alu_result = (alu_operand_2 == 16'h0) ? 16'hFFFF : alu_operand_1 / alu_operand_2;
      3'd5: alu_result = alu_operand_1 & alu_operand_2;
      3'd6: alu_result = alu_operand_1 | alu_operand_2;
      3'd7: alu_result = ~alu_operand_1;
      default: alu_result = 16'h0;
    endcase
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b01;
    tick(); tick();
    #1;
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
    vectors++; if (rsp_result !== 16'h0) begin miscompares++; $display("FAIL reset_rsp_result: got %h expected 0000", rsp_result); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    vectors++; if (alu_op !== 3'd0) begin miscompares++; $display("FAIL reset_alu_op: got %0d expected 0", alu_op); end
    req_valid = 2'b00;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_add();
    tick();
    req_valid = 2'b01; req0_op = 3'd1; req0_operand_1 = 16'h1; req0_operand_2 = 16'h1;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL add_accept: got %b expected 01", req_ready); end
    tick(); req_valid = 2'b00; #1;
    vectors++; if (alu_op !== 3'd1) begin miscompares++; $display("FAIL add_exec_op: got %0d expected 1", alu_op); end
    vectors++; if (alu_operand_1 !== 16'h1 || alu_operand_2 !== 16'h1) begin miscompares++; $display("FAIL add_exec_operands: got %h %h expected 0001 0001", alu_operand_1, alu_operand_2); end
    vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL add_exec_rsp_valid: got %b expected 00", rsp_valid); end
    tick(); #1;
    vectors++; if (rsp_valid !== 2'b01) begin miscompares++; $display("FAIL add_rsp_valid: got %b expected 01", rsp_valid); end
    vectors++; if (rsp_result !== 16'h0002) begin miscompares++; $display("FAIL add_rsp_result: got %h expected 0002", rsp_result); end
    vectors++; if (alu_op !== 3'd0) begin miscompares++; $display("FAIL add_resp_alu_nop: got %0d expected 0", alu_op); end
    rsp_ready = 2'b01;
    tick(); rsp_ready = 2'b00; #1;
    vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL add_after_handshake: got %b expected 00", rsp_valid); end
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    tick();
    req_valid = 2'b11;
    req0_op = 3'd3; req0_operand_1 = 16'h2; req0_operand_2 = 16'h2;
    req1_op = 3'd5; req1_operand_1 = 16'h5; req1_operand_2 = 16'h4;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rr_first_grant: got %b expected 01", req_ready); end
    // requester 0 immediately queues a second op (3 + 4)
    tick(); req0_op = 3'd1; req0_operand_1 = 16'h3; req0_operand_2 = 16'h4; #1;
    vectors++; if (alu_op !== 3'd3) begin miscompares++; $display("FAIL rr_exec_mul: got %0d expected 3", alu_op); end
    tick(); #1;
    vectors++; if (rsp_valid !== 2'b01 || rsp_result !== 16'h0004) begin miscompares++; $display("FAIL rr_r0_resp: got %b/%h expected 01/0004", rsp_valid, rsp_result); end
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL rr_resp_req_ready: got %b expected 00", req_ready); end
    rsp_ready = 2'b01;
    tick(); rsp_ready = 2'b00; #1;
    vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("FAIL rr_second_grant: got %b expected 10", req_ready); end
    tick(); req_valid = 2'b01; #1;
    vectors++; if (alu_op !== 3'd5 || alu_operand_1 !== 16'h5 || alu_operand_2 !== 16'h4) begin miscompares++; $display("FAIL rr_exec_and: got %0d %h %h expected 5 0005 0004", alu_op, alu_operand_1, alu_operand_2); end
    tick(); #1;
    vectors++; if (rsp_valid !== 2'b10 || rsp_result !== 16'h0004) begin miscompares++; $display("FAIL rr_r1_resp: got %b/%h expected 10/0004", rsp_valid, rsp_result); end
    rsp_ready = 2'b10;
    tick(); rsp_ready = 2'b00; #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rr_third_grant: got %b expected 01", req_ready); end
    tick(); req_valid = 2'b00;
    tick(); #1;
    vectors++; if (rsp_valid !== 2'b01 || rsp_result !== 16'h0007) begin miscompares++; $display("FAIL rr_r0_second_resp: got %b/%h expected 01/0007", rsp_valid, rsp_result); end
    rsp_ready = 2'b01;
    tick(); rsp_ready = 2'b00;
  endtask

  task automatic test_back_pressure();
    req_valid = 2'b01; req0_op = 3'd2; req0_operand_1 = 16'd10; req0_operand_2 = 16'd3;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL bp_accept: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b10; req1_op = 3'd6; req1_operand_1 = 16'h00F0; req1_operand_2 = 16'h000F;
    tick();
    for (int i = 0; i < 5; i++) begin
      rsp_ready = 2'b10;
      #1;
      vectors++; if (rsp_valid !== 2'b01 || rsp_result !== 16'h0007) begin miscompares++; $display("FAIL bp_hold_%0d: got %b/%h expected 01/0007", i, rsp_valid, rsp_result); end
      vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL bp_req_ready_%0d: got %b expected 00", i, req_ready); end
      tick();
    end
    rsp_ready = 2'b01;
    tick(); rsp_ready = 2'b00; #1;
    vectors++; if (rsp_valid !== 2'b00 || req_ready !== 2'b10) begin miscompares++; $display("FAIL bp_r1_accept: got %b/%b expected 00/10", rsp_valid, req_ready); end
    tick(); req_valid = 2'b00;
    tick(); #1;
    vectors++; if (rsp_valid !== 2'b10 || rsp_result !== 16'h00FF) begin miscompares++; $display("FAIL bp_r1_resp: got %b/%h expected 10/00ff", rsp_valid, rsp_result); end
    rsp_ready = 2'b10;
    tick(); rsp_ready = 2'b00;
  endtask

  task automatic test_div();
    req_valid = 2'b01; req0_op = 3'd4; req0_operand_1 = 16'd4; req0_operand_2 = 16'd0;
    tick(); req_valid = 2'b00; #1;
`ifdef ALU_ARB_DIV_ZERO_CHECK_EN
    vectors++; if (alu_op !== 3'd0) begin miscompares++; $display("FAIL divz_exec_op: got %0d expected 0", alu_op); end
    tick(); #1;
    vectors++; if (rsp_valid !== 2'b01 || rsp_result !== 16'hFFFF) begin miscompares++; $display("FAIL divz_resp: got %b/%h expected 01/ffff", rsp_valid, rsp_result); end
    vectors++; if (rsp_err !== 1'b1) begin miscompares++; $display("FAIL divz_err: got %b expected 1", rsp_err); end
`else
    vectors++; if (alu_op !== 3'd4) begin miscompares++; $display("FAIL divz_exec_op: got %0d expected 4", alu_op); end
    tick(); #1;
    vectors++; if (rsp_valid !== 2'b01) begin miscompares++; $display("FAIL divz_resp: got %b expected 01", rsp_valid); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL divz_err: got %b expected 0", rsp_err); end
`endif
    rsp_ready = 2'b01;
    tick(); rsp_ready = 2'b00;
    req_valid = 2'b01; req0_op = 3'd4; req0_operand_1 = 16'd9; req0_operand_2 = 16'd2;
    tick(); req_valid = 2'b00; #1;
    vectors++; if (alu_op !== 3'd4) begin miscompares++; $display("FAIL div_exec_op: got %0d expected 4", alu_op); end
    tick(); #1;
    vectors++; if (rsp_result !== 16'h0004 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL div_resp: got %h/%b expected 0004/0", rsp_result, rsp_err); end
    rsp_ready = 2'b01;
    tick(); rsp_ready = 2'b00;
  endtask

  task automatic test_reset_in_exec();
    req_valid = 2'b10; req1_op = 3'd1; req1_operand_1 = 16'd5; req1_operand_2 = 16'd6;
    tick(); #1;
    vectors++; if (alu_op !== 3'd1) begin miscompares++; $display("FAIL rst_exec_op: got %0d expected 1", alu_op); end
    rst_n = 1'b0; #1;
    vectors++; if (alu_op !== 3'd0 || rsp_valid !== 2'b00) begin miscompares++; $display("FAIL rst_async: got %0d/%b expected 0/00", alu_op, rsp_valid); end
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL rst_req_ready: got %b expected 00", req_ready); end
    tick(); req_valid = 2'b00; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL rst_no_resp_%0d: got %b expected 00", i, rsp_valid); end
      tick();
    end
    req_valid = 2'b01; req0_op = 3'd1; req0_operand_1 = 16'd1; req0_operand_2 = 16'd2;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rst_next_accept: got %b expected 01", req_ready); end
    tick(); req_valid = 2'b00;
    tick(); #1;
    vectors++; if (rsp_valid !== 2'b01 || rsp_result !== 16'h0003) begin miscompares++; $display("FAIL rst_next_resp: got %b/%h expected 01/0003", rsp_valid, rsp_result); end
    rsp_ready = 2'b01;
    tick(); rsp_ready = 2'b00;
  endtask

  task automatic test_not_r1();
    req_valid = 2'b10; req1_op = 3'd7; req1_operand_1 = 16'hAAAA; req1_operand_2 = 16'h1234;
    #1;
    vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("FAIL not_accept: got %b expected 10", req_ready); end
    tick(); req_valid = 2'b00; #1;
    vectors++; if (rsp_valid !== 2'b00 || alu_op !== 3'd7) begin miscompares++; $display("FAIL not_exec: got %b/%0d expected 00/7", rsp_valid, alu_op); end
    tick(); #1;
    vectors++; if (rsp_valid !== 2'b10 || rsp_result !== 16'h5555) begin miscompares++; $display("FAIL not_resp: got %b/%h expected 10/5555", rsp_valid, rsp_result); end
    rsp_ready = 2'b10;
    tick(); rsp_ready = 2'b00; #1;
    vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL not_done: got %b expected 00", rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_round_robin();
    test_back_pressure();
    test_div();
    test_reset_in_exec();
    test_not_r1();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the operand/result width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-005 SHALL have port req_ready  output  2  per-requester accept, one-hot or zero.
REQ-006 SHALL have ports req0_op/req1_op  input  3  requested ALU opcode.
REQ-007 SHALL have ports req0_operand_1, req0_operand_2, req1_operand_1, req1_operand_2  input  WIDTH  requested operands.
REQ-008 SHALL have port rsp_valid  output  2  per-requester response valid, one-hot or zero.
REQ-009 SHALL have port rsp_ready  input  2  per-requester response accept.
REQ-010 SHALL have port rsp_result  output  WIDTH  registered ALU result, shared by both requesters.
REQ-011 SHALL have port rsp_err  output  1  divide-by-zero flag for the current response.
REQ-012 SHALL have ports alu_op (output, 3), alu_operand_1 (output, WIDTH), alu_operand_2 (output, WIDTH) and alu_result (input, WIDTH) connecting to the combinational ALU's bus.

Function
REQ-013 SHALL use FSM states IDLE, EXEC, RESP.
REQ-014 IDLE: if any req_valid bit is set, SHALL grant one requester, assert its req_ready bit in the same cycle, latch its op and operands, and move to EXEC; otherwise SHALL stay in IDLE.
REQ-015 Grant SHALL be round-robin: when both are valid, the requester not granted most recently wins; after reset, requester 0 has priority.
REQ-016 EXEC: alu_op and alu operands SHALL be driven from the latched registers; alu_result SHALL be captured into rsp_result at the clock edge ending EXEC; the FSM SHALL then move to RESP.
REQ-017 RESP: rsp_valid bit of the granted requester SHALL be high, with rsp_result and rsp_err stable until rsp_ready of that bit is sampled high, then the FSM SHALL return to IDLE.
REQ-018 Latency SHALL be exactly 2 cycles from the accept edge to the first rsp_valid cycle; throughput SHALL be at most one operation per 3 cycles.
REQ-019 req_ready SHALL be 0 in EXEC and RESP; new requests wait, and no request is ever dropped or reordered within a requester.
REQ-020 Outside EXEC, alu_op SHALL be 3'b000 (NOP) and the alu operands SHALL be 0.
REQ-021 rsp_ready on the non-granted bit SHALL be ignored.
REQ-022 Opcode semantics belong to the ALU (1 add, 2 sub, 3 mul, 4 div, 5 and, 6 or, 7 not); the arbiter SHALL pass opcodes unmodified, including 0.

Reset
REQ-023 On rst_n low, regardless of state, SHALL enter IDLE, clear req_ready, rsp_valid, rsp_result, rsp_err, the latched registers, and alu_op/alu operands to 0, and set round-robin priority to requester 0.
REQ-024 A transaction interrupted by reset SHALL be discarded with no response.

Configuration
REQ-025 With ALU_ARB_DIV_ZERO_CHECK_EN defined, a latched op 4 with operand_2 == 0 SHALL keep alu_op at NOP during EXEC and SHALL respond with rsp_result all-ones and rsp_err = 1, with the same latency as other ops.
REQ-026 Without ALU_ARB_DIV_ZERO_CHECK_EN, every op SHALL be issued to the ALU, and rsp_err SHALL be tied to 0.

Structure
REQ-027 Package alu_pkg SHALL hold the opcode enum (ALU_NOP..ALU_NOT, 3 bits), the WIDTH default, and the FSM state enum.
REQ-028 Round-robin selection SHALL be a sub-module rr_arbiter_2 (inputs: request[1:0], last-grant; output: one-hot grant).

Verification
REQ-029 Requester 0 issues op 1, operands 1 and 1 -> req_ready[0] in the accept cycle, rsp_valid[0] 2 cycles later, rsp_result 16'h0002.
REQ-030 Both requesters issue in the same cycle after reset (r0 op 3, operands 2 and 2; r1 op 5, operands 5 and 4) -> r0 is served first with 16'h0004, then r1 with 16'h0004; the next simultaneous pair is served r1 first.
REQ-031 rsp_ready held low 5 cycles in RESP, with req_valid[1] high meanwhile -> rsp_result is held, req_ready stays 0, and r1 is accepted only in IDLE after the handshake.
REQ-032 Op 4 with operands 4 and 0, macro defined -> alu_op never shows 4, rsp_result 16'hFFFF, rsp_err 1; macro undefined -> alu_op 4 in EXEC and rsp_err 0.
REQ-033 rst_n asserted during EXEC -> rsp_valid and alu_op go 0 asynchronously, no response after release, and the next request is served normally.
REQ-034 Op 7, operand_1 16'hAAAA, through requester 1 -> rsp_valid[1] with rsp_result 16'h5555, and rsp_valid[0] stays 0.
